rob_wb_arbiter: RTL and testbench

//  Shares the ROB's single writeback port between NUM_REQ functional units (ALU, LSU, MUL, ...).

---
 rtl/rob_wb_arbiter_if.sv | 34 +++
 rtl/rob_wb_arbiter.sv | 107 ++++++++++
 tb/tb_rob_wb_arbiter.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/rob_wb_arbiter_if.sv
// rtl/rob_wb_arbiter_if.sv - functional-unit result requests and ROB writeback bundle
interface rob_wb_arbiter_if #(
    parameter int NUM_REQ  = 3,
    parameter int ROB_SIZE = 8
);
    localparam int IDX_W = $clog2(ROB_SIZE);
    localparam int SRC_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid_i;
    logic [NUM_REQ-1:0]       req_ready_o;
    logic [NUM_REQ*IDX_W-1:0] req_rob_idx_i;
    logic [NUM_REQ*32-1:0]    req_result_i;
    logic [NUM_REQ*32-1:0]    req_new_pc_i;
    logic [NUM_REQ-1:0]       req_branch_taken_i;

    logic                     wb_valid_o;
    logic [IDX_W-1:0]         wb_rob_idx_o;
    logic [31:0]              wb_result_o;
    logic [31:0]              wb_new_pc_o;
    logic                     wb_branch_taken_o;
    logic [SRC_W-1:0]         wb_src_o;

    modport master (
        output req_valid_i, req_rob_idx_i, req_result_i, req_new_pc_i, req_branch_taken_i,
        input  req_ready_o,
        input  wb_valid_o, wb_rob_idx_o, wb_result_o, wb_new_pc_o, wb_branch_taken_o, wb_src_o
    );

    modport slave (
        input  req_valid_i, req_rob_idx_i, req_result_i, req_new_pc_i, req_branch_taken_i,
        output req_ready_o,
        output wb_valid_o, wb_rob_idx_o, wb_result_o, wb_new_pc_o, wb_branch_taken_o, wb_src_o
    );
endinterface

// File: rtl/rob_wb_arbiter.sv
// rtl/rob_wb_arbiter.sv - oldest-first arbiter for the ROB single writeback port
module rob_wb_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int ROB_SIZE = 8
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic                         flush_i,
    input  logic [$clog2(ROB_SIZE)-1:0]  rob_head_i,
    rob_wb_arbiter_if.slave              bus,
    output logic [15:0]                  conflict_cnt_o
);
    localparam int IDX_W = $clog2(ROB_SIZE);
    localparam int SRC_W = $clog2(NUM_REQ);
    localparam int PC_W  = $clog2(NUM_REQ + 1);

    typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

    state_t           state, state_nxt;
    logic             grant_en;
    logic             found;
    logic [SRC_W-1:0] sel;
    logic [IDX_W-1:0] best_age;
    logic [IDX_W-1:0] age_k;
    logic [PC_W-1:0]  pop;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state <= RUN;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (flush_i) state_nxt = HOLD;
            HOLD:    state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // Reset gates grants too, so every output reads 0 while rstn_i is low.
    always_comb begin
        grant_en = rstn_i && (state == RUN) && !flush_i;
    end

    // Strict less-than keeps the lowest unit on an age tie.
    always_comb begin
        found    = 1'b0;
        sel      = '0;
        best_age = '0;
        age_k    = '0;
        pop      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            age_k = bus.req_rob_idx_i[k*IDX_W +: IDX_W] - rob_head_i;
            if (bus.req_valid_i[k]) begin
                pop = pop + PC_W'(1);
                if (!found || age_k < best_age) begin
                    found    = 1'b1;
                    sel      = SRC_W'(k);
                    best_age = age_k;
                end
            end
        end
    end

    always_comb begin
        bus.req_ready_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            bus.req_ready_o[k] = grant_en && found && (sel == SRC_W'(k));
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            bus.wb_valid_o        <= 1'b0;
            bus.wb_rob_idx_o      <= '0;
            bus.wb_result_o       <= '0;
            bus.wb_new_pc_o       <= '0;
            bus.wb_branch_taken_o <= 1'b0;
            bus.wb_src_o          <= '0;
        end else if (state == RUN && flush_i) begin
            bus.wb_valid_o        <= 1'b0;
            bus.wb_rob_idx_o      <= '0;
            bus.wb_result_o       <= '0;
            bus.wb_new_pc_o       <= '0;
            bus.wb_branch_taken_o <= 1'b0;
            bus.wb_src_o          <= '0;
        end else if (grant_en && found) begin
            bus.wb_valid_o        <= 1'b1;
            bus.wb_rob_idx_o      <= bus.req_rob_idx_i[sel*IDX_W +: IDX_W];
            bus.wb_result_o       <= bus.req_result_i[sel*32 +: 32];
            bus.wb_new_pc_o       <= bus.req_new_pc_i[sel*32 +: 32];
            bus.wb_branch_taken_o <= bus.req_branch_taken_i[sel];
            bus.wb_src_o          <= sel;
        end else begin
            bus.wb_valid_o        <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            conflict_cnt_o <= '0;
        end else if (state == RUN && !flush_i && pop >= PC_W'(2) && conflict_cnt_o != 16'hFFFF) begin
            conflict_cnt_o <= conflict_cnt_o + 16'd1;
        end
    end
endmodule

// File: tb/tb_rob_wb_arbiter.sv
// tb/tb_rob_wb_arbiter.sv - directed bench for rob_wb_arbiter
module tb_rob_wb_arbiter;
    localparam int NUM_REQ  = 3;
    localparam int ROB_SIZE = 8;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [2:0]  rob_head_i = '0;
    logic [15:0] conflict_cnt_o;

    int total_cnt = 0;
    int pass_cnt  = 0;

    rob_wb_arbiter_if #(.NUM_REQ(NUM_REQ), .ROB_SIZE(ROB_SIZE)) bus ();

    rob_wb_arbiter #(.NUM_REQ(NUM_REQ), .ROB_SIZE(ROB_SIZE)) dut (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .flush_i        (flush_i),
        .rob_head_i     (rob_head_i),
        .bus            (bus),
        .conflict_cnt_o (conflict_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic set_req(input int k, input logic v, input logic [2:0] idx,
                           input logic [31:0] res, input logic [31:0] pc, input logic bt);
        bus.req_valid_i[k]            = v;
        bus.req_rob_idx_i[k*3 +: 3]   = idx;
        bus.req_result_i[k*32 +: 32]  = res;
        bus.req_new_pc_i[k*32 +: 32]  = pc;
        bus.req_branch_taken_i[k]     = bt;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        bus.req_valid_i = '0;
        bus.req_rob_idx_i = '0;
        bus.req_result_i = '0;
        bus.req_new_pc_i = '0;
        bus.req_branch_taken_i = '0;
        rstn_i = 1'b0;
        step();
        total_cnt++;
        if ({bus.wb_valid_o, bus.wb_rob_idx_o, bus.wb_result_o, bus.wb_src_o, conflict_cnt_o, bus.req_ready_o} !== '0)
            $display("FAIL reset_outputs: wb_valid=%b idx=%0d res=%h src=%0d cnt=%0d ready=%b, required all 0",
                     bus.wb_valid_o, bus.wb_rob_idx_o, bus.wb_result_o, bus.wb_src_o, conflict_cnt_o, bus.req_ready_o);
        else pass_cnt++;
        rstn_i = 1'b1;
        step();
    endtask

    task automatic test_single();
        rob_head_i = 3'd0;
        set_req(1, 1'b1, 3'd3, 32'h1111_2222, 32'h0000_4000, 1'b1);
        #1;
        total_cnt++;
        if (bus.req_ready_o !== 3'b010) $display("FAIL single_ready: got %b, required 010", bus.req_ready_o);
        else pass_cnt++;
        step();
        set_req(1, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        total_cnt++;
        if ({bus.wb_valid_o, bus.wb_rob_idx_o, bus.wb_src_o, bus.wb_result_o, bus.wb_new_pc_o, bus.wb_branch_taken_o}
            !== {1'b1, 3'd3, 2'd1, 32'h1111_2222, 32'h0000_4000, 1'b1})
            $display("FAIL single_wb: valid=%b idx=%0d src=%0d res=%h pc=%h bt=%b, required 1/3/1/11112222/00004000/1",
                     bus.wb_valid_o, bus.wb_rob_idx_o, bus.wb_src_o, bus.wb_result_o, bus.wb_new_pc_o, bus.wb_branch_taken_o);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({bus.wb_valid_o, bus.wb_rob_idx_o, bus.wb_result_o} !== {1'b0, 3'd3, 32'h1111_2222})
            $display("FAIL single_idle_hold: valid=%b idx=%0d res=%h, required 0/3/11112222",
                     bus.wb_valid_o, bus.wb_rob_idx_o, bus.wb_result_o);
        else pass_cnt++;
    endtask

    task automatic test_age_order();
        rob_head_i = 3'd2;
        set_req(0, 1'b1, 3'd5, 32'hA0, 32'h0, 1'b0);
        set_req(1, 1'b1, 3'd2, 32'hA1, 32'h0, 1'b0);
        set_req(2, 1'b1, 3'd4, 32'hA2, 32'h0, 1'b0);
        #1;
        total_cnt++;
        if (bus.req_ready_o !== 3'b010) $display("FAIL age_ready0: got %b, required 010", bus.req_ready_o);
        else pass_cnt++;
        step();
        set_req(1, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        #1;
        total_cnt++;
        if ({bus.wb_valid_o, bus.wb_src_o, bus.req_ready_o} !== {1'b1, 2'd1, 3'b100})
            $display("FAIL age_step1: valid=%b src=%0d ready=%b, required 1/1/100", bus.wb_valid_o, bus.wb_src_o, bus.req_ready_o);
        else pass_cnt++;
        step();
        set_req(2, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        #1;
        total_cnt++;
        if ({bus.wb_valid_o, bus.wb_src_o, bus.wb_rob_idx_o, bus.req_ready_o} !== {1'b1, 2'd2, 3'd4, 3'b001})
            $display("FAIL age_step2: valid=%b src=%0d idx=%0d ready=%b, required 1/2/4/001",
                     bus.wb_valid_o, bus.wb_src_o, bus.wb_rob_idx_o, bus.req_ready_o);
        else pass_cnt++;
        step();
        set_req(0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        total_cnt++;
        if ({bus.wb_valid_o, bus.wb_src_o, bus.wb_result_o, conflict_cnt_o} !== {1'b1, 2'd0, 32'hA0, 16'd2})
            $display("FAIL age_step3: valid=%b src=%0d res=%h cnt=%0d, required 1/0/a0/2",
                     bus.wb_valid_o, bus.wb_src_o, bus.wb_result_o, conflict_cnt_o);
        else pass_cnt++;
        step();
    endtask

    task automatic test_wrap();
        rob_head_i = 3'd6;
        set_req(0, 1'b1, 3'd0, 32'hB0, 32'h0, 1'b0);
        set_req(2, 1'b1, 3'd7, 32'hB2, 32'h0, 1'b0);
        #1;
        total_cnt++;
        if (bus.req_ready_o !== 3'b100) $display("FAIL wrap_ready0: got %b, required 100", bus.req_ready_o);
        else pass_cnt++;
        step();
        set_req(2, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        #1;
        total_cnt++;
        if ({bus.wb_src_o, bus.wb_rob_idx_o, bus.req_ready_o} !== {2'd2, 3'd7, 3'b001})
            $display("FAIL wrap_step1: src=%0d idx=%0d ready=%b, required 2/7/001", bus.wb_src_o, bus.wb_rob_idx_o, bus.req_ready_o);
        else pass_cnt++;
        step();
        set_req(0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        total_cnt++;
        if ({bus.wb_valid_o, bus.wb_src_o, bus.wb_rob_idx_o} !== {1'b1, 2'd0, 3'd0})
            $display("FAIL wrap_step2: valid=%b src=%0d idx=%0d, required 1/0/0", bus.wb_valid_o, bus.wb_src_o, bus.wb_rob_idx_o);
        else pass_cnt++;
        step();
    endtask

    task automatic test_flush();
        rob_head_i = 3'd0;
        set_req(0, 1'b1, 3'd1, 32'hC0, 32'h0, 1'b0);
        set_req(1, 1'b1, 3'd2, 32'hC1, 32'h0, 1'b0);
        step();
        set_req(0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        set_req(2, 1'b1, 3'd3, 32'hC2, 32'h0, 1'b0);
        flush_i = 1'b1;
        #1;
        total_cnt++;
        if ({bus.wb_valid_o, bus.wb_src_o, bus.req_ready_o} !== {1'b1, 2'd0, 3'b000})
            $display("FAIL flush_n1: valid=%b src=%0d ready=%b, required 1/0/000", bus.wb_valid_o, bus.wb_src_o, bus.req_ready_o);
        else pass_cnt++;
        step();
        #1;
        total_cnt++;
        if ({bus.wb_valid_o, bus.req_ready_o} !== {1'b0, 3'b000})
            $display("FAIL flush_hold: valid=%b ready=%b, required 0/000", bus.wb_valid_o, bus.req_ready_o);
        else pass_cnt++;
        step();
        flush_i = 1'b0;
        #1;
        total_cnt++;
        if ({bus.wb_valid_o, bus.req_ready_o} !== {1'b0, 3'b010})
            $display("FAIL flush_resume: valid=%b ready=%b, required 0/010", bus.wb_valid_o, bus.req_ready_o);
        else pass_cnt++;
        step();
        set_req(1, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        total_cnt++;
        if ({bus.wb_valid_o, bus.wb_src_o, bus.wb_result_o, conflict_cnt_o} !== {1'b1, 2'd1, 32'hC1, 16'd5})
            $display("FAIL flush_wb: valid=%b src=%0d res=%h cnt=%0d, required 1/1/c1/5",
                     bus.wb_valid_o, bus.wb_src_o, bus.wb_result_o, conflict_cnt_o);
        else pass_cnt++;
    endtask

    task automatic test_saturation();
        set_req(2, 1'b1, 3'd3, 32'hC2, 32'h0, 1'b0);
        set_req(0, 1'b1, 3'd4, 32'hD0, 32'h0, 1'b0);
        repeat (65529) @(posedge clk_i);
        #1;
        total_cnt++;
        if (conflict_cnt_o !== 16'hFFFE) $display("FAIL sat_before: got %h, required fffe", conflict_cnt_o);
        else pass_cnt++;
        step();
        total_cnt++;
        if (conflict_cnt_o !== 16'hFFFF) $display("FAIL sat_reach: got %h, required ffff", conflict_cnt_o);
        else pass_cnt++;
        repeat (4470) @(posedge clk_i);
        #1;
        total_cnt++;
        if (conflict_cnt_o !== 16'hFFFF) $display("FAIL sat_hold: got %h, required ffff", conflict_cnt_o);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        #2;
        rstn_i = 1'b0;
        #1;
        total_cnt++;
        if ({bus.wb_valid_o, bus.wb_rob_idx_o, bus.wb_result_o, bus.wb_src_o, conflict_cnt_o, bus.req_ready_o} !== '0)
            $display("FAIL areset_outputs: valid=%b idx=%0d res=%h src=%0d cnt=%h ready=%b, required all 0",
                     bus.wb_valid_o, bus.wb_rob_idx_o, bus.wb_result_o, bus.wb_src_o, conflict_cnt_o, bus.req_ready_o);
        else pass_cnt++;
        #2;
        rstn_i = 1'b1;
        #1;
        total_cnt++;
        if (bus.req_ready_o !== 3'b100) $display("FAIL areset_run: ready=%b, required 100", bus.req_ready_o);
        else pass_cnt++;
        bus.req_valid_i = '0;
        step();
        total_cnt++;
        if (bus.wb_valid_o !== 1'b0) $display("FAIL areset_no_wb: valid=%b, required 0", bus.wb_valid_o);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_age_order();
        test_wrap();
        test_flush();
        test_saturation();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
